pwm_multi_channel: RTL

//   N-channel PWM generator; successor to the single-channel button-driven PWM.

---
 rtl/pwm_multi_channel.sv | 196 +++++++++++++++++++
 1 files changed

// File: rtl/pwm_multi_channel.sv
// Multi-channel PWM generator.
// One shared counter (edge- or center-aligned) drives CHANNELS comparators.
// Each channel owns an active duty register (changed by host writes or by
// debounced up/down buttons) and a shadow copy that only reloads at a period
// boundary, so a duty change never produces a runt or stretched pulse.
module pwm_multi_channel #(
   parameter int CHANNELS     = 4,
   parameter int CNT_W        = 8,
   parameter int PERIOD       = 10,
   parameter int STEP         = 1,
   parameter int DUTY_INIT    = 5,
   parameter int DEBOUNCE_CYC = 25_000_000,
   localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      enable,
   input  logic                      center_mode,
   input  logic [CHANNELS-1:0]       inc_btn,
   input  logic [CHANNELS-1:0]       dec_btn,
   input  logic                      wr_en,
   input  logic [CH_W-1:0]           wr_ch,
   input  logic [CNT_W-1:0]          wr_data,
   output logic [CHANNELS-1:0]       pwm_out,
   output logic                      period_start,
   output logic [CHANNELS*CNT_W-1:0] duty_rd
);

   localparam int PS_W = $clog2(DEBOUNCE_CYC);

   localparam logic [PS_W-1:0]  PS_LAST  = PS_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] PERIOD_C = CNT_W'(PERIOD);
   localparam logic [CNT_W-1:0] LAST_C   = CNT_W'(PERIOD - 1);
   localparam logic [CNT_W-1:0] INIT_C   = CNT_W'(DUTY_INIT);
   localparam logic [CNT_W-1:0] STEP_C   = CNT_W'(STEP);
   localparam logic [CNT_W:0]   PERIOD_X = (CNT_W + 1)'(PERIOD);
   localparam logic [CNT_W:0]   STEP_X   = (CNT_W + 1)'(STEP);

   // ---------------------------------------------------------------
   // Button conditioning: synchroniser, slow sampling, 2-sample
   // hysteresis, rising-edge detect.
   // ---------------------------------------------------------------
   logic [CHANNELS-1:0] r_inc_s1, r_inc_s2, r_inc_smp, r_inc_deb, r_inc_deb_d;
   logic [CHANNELS-1:0] r_dec_s1, r_dec_s2, r_dec_smp, r_dec_deb, r_dec_deb_d;
   logic [PS_W-1:0]     r_presc;
   logic                w_tick;
   logic [CHANNELS-1:0] w_inc_step, w_dec_step;

   assign w_tick     = (r_presc == PS_LAST);
   assign w_inc_step = r_inc_deb & ~r_inc_deb_d;
   assign w_dec_step = r_dec_deb & ~r_dec_deb_d;

   // Synchronise raw buttons, run the sample prescaler and debounce on each tick.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_inc_s1    <= '0;
         r_inc_s2    <= '0;
         r_inc_smp   <= '0;
         r_inc_deb   <= '0;
         r_inc_deb_d <= '0;
         r_dec_s1    <= '0;
         r_dec_s2    <= '0;
         r_dec_smp   <= '0;
         r_dec_deb   <= '0;
         r_dec_deb_d <= '0;
         r_presc     <= '0;
      end else begin
         r_inc_s1    <= inc_btn;
         r_inc_s2    <= r_inc_s1;
         r_dec_s1    <= dec_btn;
         r_dec_s2    <= r_dec_s1;
         r_inc_deb_d <= r_inc_deb;
         r_dec_deb_d <= r_dec_deb;
         r_presc     <= w_tick ? '0 : r_presc + 1'b1;
         if (w_tick) begin
            // Level flips only when the current and previous samples agree.
            r_inc_smp <= r_inc_s2;
            r_dec_smp <= r_dec_s2;
            r_inc_deb <= (r_inc_s2 & r_inc_smp) | (r_inc_deb & (r_inc_s2 | r_inc_smp));
            r_dec_deb <= (r_dec_s2 & r_dec_smp) | (r_dec_deb & (r_dec_s2 | r_dec_smp));
         end
      end
   end

   // ---------------------------------------------------------------
   // Shared period counter.
   // ---------------------------------------------------------------
   logic [CNT_W-1:0] r_cnt;
   logic             r_dir_up;
   logic             r_center;
   logic             w_boundary;
   logic             r_period_start;

   // A period begins whenever the counter sits at 0 moving up; while disabled
   // the counter parks there, so the first enabled cycle is a boundary.
   assign w_boundary = enable && (r_cnt == '0) && r_dir_up;

   // Advance the counter; in center mode turn around at both ends, holding each
   // end value for two cycles so the full period is 2*PERIOD.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt    <= '0;
         r_dir_up <= 1'b1;
         r_center <= 1'b0;
      end else if (!enable) begin
         r_cnt    <= '0;
         r_dir_up <= 1'b1;
      end else begin
         if (w_boundary) begin
            r_center <= center_mode;
         end
         if (r_dir_up) begin
            if (r_cnt == LAST_C) begin
               if (r_center) begin
                  r_dir_up <= 1'b0;
               end else begin
                  r_cnt <= '0;
               end
            end else begin
               r_cnt <= r_cnt + 1'b1;
            end
         end else begin
            if (r_cnt == '0) begin
               r_dir_up <= 1'b1;
            end else begin
               r_cnt <= r_cnt - 1'b1;
            end
         end
      end
   end

   // Period marker, registered so it lines up with the pwm_out sample of cnt=0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_period_start <= 1'b0;
      end else begin
         r_period_start <= w_boundary;
      end
   end

   assign period_start = r_period_start;

   // ---------------------------------------------------------------
   // Per-channel duty, shadow and comparator.
   // ---------------------------------------------------------------
   genvar gi;
   generate
      for (gi = 0; gi < CHANNELS; gi++) begin : g_ch
         logic [CNT_W-1:0] r_duty;
         logic [CNT_W-1:0] r_shadow;
         logic [CNT_W-1:0] w_duty_next;
         logic [CNT_W-1:0] w_cmp;
         logic [CNT_W:0]   w_inc_sum;
         logic             w_hit;
         logic             r_pwm;

         // Out-of-range channel numbers never equal any gi, so they are dropped.
         assign w_hit     = wr_en && (32'(wr_ch) == gi);
         assign w_inc_sum = {1'b0, r_duty} + STEP_X;
         // On the boundary cycle compare against the duty being loaded, so the
         // very first count of the new period already uses the new value.
         assign w_cmp     = w_boundary ? r_duty : r_shadow;

         // Next duty: host write beats buttons; opposing steps cancel; saturate.
         always_comb begin
            w_duty_next = r_duty;
            if (w_hit) begin
               w_duty_next = (wr_data > PERIOD_C) ? PERIOD_C : wr_data;
            end else if (w_inc_step[gi] && !w_dec_step[gi]) begin
               w_duty_next = (w_inc_sum > PERIOD_X) ? PERIOD_C : w_inc_sum[CNT_W-1:0];
            end else if (w_dec_step[gi] && !w_inc_step[gi]) begin
               w_duty_next = ({1'b0, r_duty} < STEP_X) ? '0 : r_duty - STEP_C;
            end
         end

         // Hold active duty, reload the shadow at boundaries, register the output.
         always_ff @(posedge clk) begin
            if (rst) begin
               r_duty   <= INIT_C;
               r_shadow <= INIT_C;
               r_pwm    <= 1'b0;
            end else begin
               r_duty <= w_duty_next;
               if (w_boundary) begin
                  r_shadow <= r_duty;
               end
               r_pwm <= enable && (r_cnt < w_cmp);
            end
         end

         assign pwm_out[gi]                   = r_pwm;
         assign duty_rd[gi*CNT_W +: CNT_W]    = r_duty;
      end
   endgenerate

endmodule
